// File: rtl/vend_pkg.sv
// Shared vending definitions: coin codes, change codes, dispenser states and
// the change-code decoder used by change_dispenser.
package vend_pkg;

  localparam logic [1:0] NICKEL  = 2'd1;
  localparam logic [1:0] DIME    = 2'd2;
  localparam logic [1:0] QUARTER = 2'd3;

  localparam int unsigned NICKEL_VAL  = 1;
  localparam int unsigned DIME_VAL    = 2;
  localparam int unsigned QUARTER_VAL = 5;

  localparam logic [2:0] CHG_NONE        = 3'd0;
  localparam logic [2:0] CHG_NICKEL      = 3'd1;
  localparam logic [2:0] CHG_DIME        = 3'd2;
  localparam logic [2:0] CHG_NICKEL_DIME = 3'd3;
  localparam logic [2:0] CHG_DIME_DIME   = 3'd4;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_PULSE = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;
  localparam logic [2:0] S_FAULT = 3'd5;

  typedef struct packed {
    logic [1:0] dimes;
    logic [1:0] nickels;
  } coin_count_t;

  function automatic logic is_request(input logic [2:0] code);
    return (code >= CHG_NICKEL) && (code <= CHG_DIME_DIME);
  endfunction

  function automatic coin_count_t decode_change(input logic [2:0] code);
    coin_count_t c;
    c = '0;
    case (code)
      CHG_NICKEL:      c.nickels = 2'd1;
      CHG_DIME:        c.dimes   = 2'd1;
      CHG_NICKEL_DIME: begin
        c.nickels = 2'd1;
        c.dimes   = 2'd1;
      end
      CHG_DIME_DIME:   c.dimes   = 2'd2;
      default:         c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/disp_timer.sv
// Loadable down-counter with a registered zero flag; shared by the solenoid
// pulse window and the exit-sensor timeout.
module disp_timer #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
      zero  <= 1'b1;
    end else if (load) begin
      count <= load_val;
      zero  <= (load_val == '0);
    end else if (dec && !zero) begin
      count <= count - CNT_W'(1);
      zero  <= (count == CNT_W'(1));
    end
  end

endmodule

// File: rtl/change_dispenser.sv
// Change dispenser: queues change requests in a one-deep slot and ejects coins
// one at a time, dimes first. Define CHANGE_DISP_TIMEOUT_EN for sensor timeout.
module change_dispenser
  import vend_pkg::*;
#(
  parameter int unsigned PULSE_CYCLES   = 4,
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned CNT_W          = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [2:0] change,
  input  logic       coin_sensed,
  output logic       nickel_sol,
  output logic       dime_sol,
  output logic       busy,
  output logic       done,
  output logic       fault,
  output logic       overflow,
  output logic [7:0] paid_total
);

  localparam logic [CNT_W-1:0] PULSE_LOAD   = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [2:0] state, state_d;
  logic       slot_full, slot_full_d;
  logic [2:0] slot_code, slot_code_d;
  logic [1:0] dime_cnt, dime_cnt_d, nickel_cnt, nickel_cnt_d;
  logic [1:0] sel, sel_d;
  logic       early, early_d;
  logic [7:0] paid_d;
  logic       overflow_d;
  logic       tmr_load, tmr_dec, tmr_zero;
  logic [CNT_W-1:0] tmr_val;
  logic       req, consume;
  coin_count_t slot_coins;

  disp_timer #(.CNT_W(CNT_W)) u_timer (
    .clock    (clock),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .dec      (tmr_dec),
    .zero     (tmr_zero)
  );

  // State register and registered outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= S_IDLE;
      slot_full  <= 1'b0;
      slot_code  <= CHG_NONE;
      dime_cnt   <= '0;
      nickel_cnt <= '0;
      sel        <= NICKEL;
      early      <= 1'b0;
      paid_total <= '0;
      overflow   <= 1'b0;
      dime_sol   <= 1'b0;
      nickel_sol <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_d;
      slot_full  <= slot_full_d;
      slot_code  <= slot_code_d;
      dime_cnt   <= dime_cnt_d;
      nickel_cnt <= nickel_cnt_d;
      sel        <= sel_d;
      early      <= early_d;
      paid_total <= paid_d;
      overflow   <= overflow_d;
      dime_sol   <= (state_d == S_PULSE) && (sel_d == DIME);
      nickel_sol <= (state_d == S_PULSE) && (sel_d == NICKEL);
      busy       <= (state_d != S_IDLE) || slot_full_d;
      done       <= (state_d == S_DONE);
    end
  end

`ifdef CHANGE_DISP_TIMEOUT_EN
  always_ff @(posedge clock) begin
    if (reset) fault <= 1'b0;
    else       fault <= (state_d == S_FAULT);
  end
`else
  assign fault = 1'b0;
`endif

  // Next-state, slot and counter logic
  always_comb begin
    state_d      = state;
    slot_full_d  = slot_full;
    slot_code_d  = slot_code;
    dime_cnt_d   = dime_cnt;
    nickel_cnt_d = nickel_cnt;
    sel_d        = sel;
    early_d      = early;
    paid_d       = paid_total;
    overflow_d   = overflow;
    tmr_load     = 1'b0;
    tmr_val      = PULSE_LOAD;
    tmr_dec      = 1'b0;
    consume      = 1'b0;
    slot_coins   = decode_change(slot_code);
    req          = is_request(change) && (state != S_FAULT);

    case (state)
      S_IDLE: begin
        if (slot_full) begin
          dime_cnt_d   = slot_coins.dimes;
          nickel_cnt_d = slot_coins.nickels;
          consume      = 1'b1;
          state_d      = S_LOAD;
        end
      end
      S_LOAD: begin
        early_d = 1'b0;
        if (dime_cnt != 2'd0) begin
          sel_d    = DIME;
          state_d  = S_PULSE;
          tmr_load = 1'b1;
        end else if (nickel_cnt != 2'd0) begin
          sel_d    = NICKEL;
          state_d  = S_PULSE;
          tmr_load = 1'b1;
        end else begin
          state_d = S_DONE;
        end
      end
      S_PULSE: begin
        // A sensor pulse during the window confirms the coin early, once
        if (coin_sensed && !early) begin
          early_d = 1'b1;
          if (sel == DIME) begin
            dime_cnt_d = dime_cnt - 2'd1;
            paid_d     = paid_total + 8'(DIME_VAL);
          end else begin
            nickel_cnt_d = nickel_cnt - 2'd1;
            paid_d       = paid_total + 8'(NICKEL_VAL);
          end
        end
        if (tmr_zero) begin
          state_d  = early_d ? S_LOAD : S_WAIT;
          tmr_load = 1'b1;
          tmr_val  = TIMEOUT_LOAD;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      S_WAIT: begin
        if (coin_sensed) begin
          state_d = S_LOAD;
          if (sel == DIME) begin
            dime_cnt_d = dime_cnt - 2'd1;
            paid_d     = paid_total + 8'(DIME_VAL);
          end else begin
            nickel_cnt_d = nickel_cnt - 2'd1;
            paid_d       = paid_total + 8'(NICKEL_VAL);
          end
        end
`ifdef CHANGE_DISP_TIMEOUT_EN
        else if (tmr_zero) begin
          state_d = S_FAULT;
        end
`endif
        else begin
          tmr_dec = 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_IDLE;
    endcase

    if (req) begin
      if (slot_full && !consume) begin
        overflow_d = 1'b1;
      end else begin
        slot_full_d = 1'b1;
        slot_code_d = change;
      end
    end else if (consume) begin
      slot_full_d = 1'b0;
    end
  end

endmodule

// File: tb/tb_change_dispenser.sv
// Directed self-checking bench for change_dispenser; fault scenario follows
// the CHANGE_DISP_TIMEOUT_EN build option.
module tb_change_dispenser;

  logic       clock;
  logic       reset;
  logic [2:0] change;
  logic       coin_sensed;
  logic       nickel_sol, dime_sol, busy, done, fault, overflow;
  logic [7:0] paid_total;

  int passed = 0;
  int total  = 0;

  change_dispenser dut (
    .clock       (clock),
    .reset       (reset),
    .change      (change),
    .coin_sensed (coin_sensed),
    .nickel_sol  (nickel_sol),
    .dime_sol    (dime_sol),
    .busy        (busy),
    .done        (done),
    .fault       (fault),
    .overflow    (overflow),
    .paid_total  (paid_total)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    change = 3'd0;
    coin_sensed = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  // One DIME request, confirmed on the first WAIT cycle; returns to idle.
  task automatic serve_dime();
    change = 3'd2;
    step();
    change = 3'd0;
    repeat (6) step();
    coin_sensed = 1'b1;
    step();
    coin_sensed = 1'b0;
    repeat (2) step();
  endtask

  task automatic test_reset();
    do_reset();
    total++; if ({nickel_sol, dime_sol, busy, done, fault, overflow} !== 6'b0) $display("FAIL rst_outs: got %b expected 000000", {nickel_sol, dime_sol, busy, done, fault, overflow}); else passed++;
    total++; if (paid_total !== 8'd0) $display("FAIL rst_paid: got %0d expected 0", paid_total); else passed++;
    change = 3'd2;
    for (int c = 1; c <= 4; c++) begin
      step();
      change = 3'd0;
    end
    total++; if (dime_sol !== 1'b1) $display("FAIL mid_pulse_sol: got %b expected 1", dime_sol); else passed++;
    reset = 1'b1;
    step();
    reset = 1'b0;
    total++; if ({nickel_sol, dime_sol, busy} !== 3'b0) $display("FAIL mid_reset_outs: got %b expected 000", {nickel_sol, dime_sol, busy}); else passed++;
    repeat (10) step();
    total++; if ({dime_sol, busy, done} !== 3'b0) $display("FAIL mid_reset_abandon: got %b expected 000", {dime_sol, busy, done}); else passed++;
  endtask

  task automatic test_dime_dime();
    logic exp_d;
    int ndone = 0;
    do_reset();
    change = 3'd4;
    for (int c = 1; c <= 19; c++) begin
      step();
      change = 3'd0;
      coin_sensed = (c == 8) || (c == 15);
      exp_d = (c >= 3 && c <= 6) || (c >= 10 && c <= 13);
      if (done === 1'b1) ndone++;
      total++; if (dime_sol !== exp_d) $display("FAIL dd_dime c%0d: got %b expected %b", c, dime_sol, exp_d); else passed++;
      total++; if (nickel_sol !== 1'b0) $display("FAIL dd_nickel c%0d: got %b expected 0", c, nickel_sol); else passed++;
      total++; if (done !== (c == 17)) $display("FAIL dd_done c%0d: got %b expected %b", c, done, c == 17); else passed++;
    end
    coin_sensed = 1'b0;
    total++; if (ndone != 1) $display("FAIL dd_done_count: got %0d expected 1", ndone); else passed++;
    total++; if (paid_total !== 8'd4) $display("FAIL dd_paid: got %0d expected 4", paid_total); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL dd_busy_end: got %b expected 0", busy); else passed++;
  endtask

  // Dime confirmed early (sensor during its pulse), nickel confirmed in WAIT.
  task automatic test_nickel_dime();
    logic exp_d, exp_n;
    int ndone = 0;
    do_reset();
    change = 3'd3;
    for (int c = 1; c <= 17; c++) begin
      step();
      change = 3'd0;
      coin_sensed = (c == 5) || (c == 13);
      exp_d = (c >= 3 && c <= 6);
      exp_n = (c >= 8 && c <= 11);
      if (done === 1'b1) ndone++;
      total++; if (dime_sol !== exp_d) $display("FAIL nd_dime c%0d: got %b expected %b", c, dime_sol, exp_d); else passed++;
      total++; if (nickel_sol !== exp_n) $display("FAIL nd_nickel c%0d: got %b expected %b", c, nickel_sol, exp_n); else passed++;
      if (c == 7) begin
        total++; if (paid_total !== 8'd2) $display("FAIL nd_paid_early: got %0d expected 2", paid_total); else passed++;
      end
      if (c == 15) begin
        total++; if (done !== 1'b1) $display("FAIL nd_done: got %b expected 1", done); else passed++;
      end
    end
    coin_sensed = 1'b0;
    total++; if (ndone != 1) $display("FAIL nd_done_count: got %0d expected 1", ndone); else passed++;
    total++; if (paid_total !== 8'd3) $display("FAIL nd_paid: got %0d expected 3", paid_total); else passed++;
  endtask

  task automatic test_fault();
    do_reset();
    change = 3'd2;
`ifdef CHANGE_DISP_TIMEOUT_EN
    for (int c = 1; c <= 76; c++) begin
      step();
      change = (c >= 72 && c <= 74) ? 3'd1 : 3'd0;
      total++; if (fault !== (c >= 71)) $display("FAIL flt_fault c%0d: got %b expected %b", c, fault, c >= 71); else passed++;
      total++; if (dime_sol !== (c >= 3 && c <= 6)) $display("FAIL flt_dime c%0d: got %b expected %b", c, dime_sol, c >= 3 && c <= 6); else passed++;
      total++; if (overflow !== 1'b0) $display("FAIL flt_overflow c%0d: got %b expected 0", c, overflow); else passed++;
    end
    total++; if ({nickel_sol, busy, paid_total} !== {1'b0, 1'b1, 8'd0}) $display("FAIL flt_hold: got nickel=%b busy=%b paid=%0d expected 0 1 0", nickel_sol, busy, paid_total); else passed++;
    reset = 1'b1;
    step();
    reset = 1'b0;
    total++; if ({fault, busy, overflow, dime_sol, nickel_sol} !== 5'b0) $display("FAIL flt_reset: got %b expected 00000", {fault, busy, overflow, dime_sol, nickel_sol}); else passed++;
`else
    for (int c = 1; c <= 100; c++) begin
      step();
      change = 3'd0;
    end
    total++; if ({fault, busy, dime_sol} !== 3'b010) $display("FAIL nto_wait: got %b expected 010", {fault, busy, dime_sol}); else passed++;
    coin_sensed = 1'b1;
    step();
    coin_sensed = 1'b0;
    total++; if (paid_total !== 8'd2) $display("FAIL nto_paid: got %0d expected 2", paid_total); else passed++;
    step();
    total++; if (done !== 1'b1) $display("FAIL nto_done: got %b expected 1", done); else passed++;
`endif
  endtask

  task automatic test_overflow();
    do_reset();
    change = 3'd2;
    for (int c = 1; c <= 21; c++) begin
      step();
      change = (c == 1) ? 3'd1 : (c == 2) ? 3'd2 : 3'd0;
      coin_sensed = (c == 8) || (c == 18);
      if (c == 2) begin
        total++; if (overflow !== 1'b0) $display("FAIL ov_early: got %b expected 0", overflow); else passed++;
      end
      if (c == 3) begin
        total++; if (overflow !== 1'b1) $display("FAIL ov_set: got %b expected 1", overflow); else passed++;
      end
      total++; if (done !== (c == 10 || c == 20)) $display("FAIL ov_done c%0d: got %b expected %b", c, done, c == 10 || c == 20); else passed++;
      total++; if (nickel_sol !== (c >= 13 && c <= 16)) $display("FAIL ov_nickel c%0d: got %b expected %b", c, nickel_sol, c >= 13 && c <= 16); else passed++;
      if (c == 11) begin
        total++; if (busy !== 1'b1) $display("FAIL ov_busy_slot: got %b expected 1", busy); else passed++;
      end
    end
    coin_sensed = 1'b0;
    total++; if (paid_total !== 8'd3) $display("FAIL ov_paid: got %0d expected 3", paid_total); else passed++;
    total++; if ({busy, overflow} !== 2'b01) $display("FAIL ov_end: got %b expected 01", {busy, overflow}); else passed++;
  endtask

  task automatic test_invalid();
    do_reset();
    for (int c = 0; c <= 9; c++) begin
      change = (c >= 0 && c <= 2) ? 3'(5 + c) : 3'd0;
      coin_sensed = (c == 3);
      step();
      total++; if ({nickel_sol, dime_sol, busy, overflow} !== 4'b0) $display("FAIL inv_outs c%0d: got %b expected 0000", c, {nickel_sol, dime_sol, busy, overflow}); else passed++;
    end
    coin_sensed = 1'b0;
    total++; if (paid_total !== 8'd0) $display("FAIL inv_paid: got %0d expected 0", paid_total); else passed++;
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 127; i++) serve_dime();
    total++; if (paid_total !== 8'd254) $display("FAIL wrap_pre: got %0d expected 254", paid_total); else passed++;
    serve_dime();
    total++; if (paid_total !== 8'd0) $display("FAIL wrap_post: got %0d expected 0", paid_total); else passed++;
  endtask

  initial begin
    reset = 1'b1;
    change = 3'd0;
    coin_sensed = 1'b0;
    test_reset();
    test_dime_dime();
    test_nickel_dime();
    test_fault();
    test_overflow();
    test_invalid();
    test_wrap();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
